// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side (fetch, load/store) and memory-side signals around the port arbiter.
// The slave view belongs to the arbiter; the master view belongs to the requesters and the memory.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic        ls_err;
    logic [31:0] rdata;
    logic        addr_sel;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, rdata,
        output addr_sel, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_be, mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err, rdata,
        input  addr_sel, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one 32-bit memory port between instruction fetch and load/store, one access at a time,
// with round-robin on conflicts and a per-access timeout.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        LS_BUSY = 2'd2
    } state_t;

    state_t            state_reg;
    logic              last_ls_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              addr_sel_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [31:0]       mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic [3:0]        mem_be_reg;
    logic              if_gnt_reg;
    logic              ls_gnt_reg;

    logic              busy;
    logic              done;
    logic              expire;
    logic              grant_ls;
    logic              grant_if;
    logic [31:0]       addr_mux;

    assign busy   = (state_reg != IDLE);
    assign done   = busy && bus.mem_ready;
    // mem_ready on the final allowed cycle still completes the access normally
    assign expire = busy && !bus.mem_ready && (cnt_reg == CNT_W'(TIMEOUT - 1));

    // On a conflict the requester that did not own the port last time wins
    assign grant_ls = (state_reg == IDLE) && bus.ls_req && (!bus.if_req || !last_ls_reg);
    assign grant_if = (state_reg == IDLE) && bus.if_req && !grant_ls;
    assign addr_mux = grant_ls ? bus.ls_addr : bus.if_addr;

    assign bus.if_rvalid = done   && (state_reg == IF_BUSY);
    assign bus.ls_rvalid = done   && (state_reg == LS_BUSY);
    assign bus.if_err    = expire && (state_reg == IF_BUSY);
    assign bus.ls_err    = expire && (state_reg == LS_BUSY);
    assign bus.rdata     = (done && !mem_we_reg) ? bus.mem_rdata : 32'd0;

    assign bus.if_gnt    = if_gnt_reg;
    assign bus.ls_gnt    = ls_gnt_reg;
    assign bus.addr_sel  = addr_sel_reg;
    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_be    = mem_be_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            last_ls_reg   <= 1'b0;
            cnt_reg       <= '0;
            addr_sel_reg  <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
            mem_be_reg    <= 4'd0;
            if_gnt_reg    <= 1'b0;
            ls_gnt_reg    <= 1'b0;
        end else begin
            if_gnt_reg <= 1'b0;
            ls_gnt_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_ls) begin
                        state_reg     <= LS_BUSY;
                        last_ls_reg   <= 1'b1;
                        cnt_reg       <= '0;
                        addr_sel_reg  <= 1'b1;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= bus.ls_we;
                        mem_addr_reg  <= addr_mux;
                        mem_wdata_reg <= bus.ls_wdata;
                        mem_be_reg    <= bus.ls_be;
                        ls_gnt_reg    <= 1'b1;
                    end else if (grant_if) begin
                        state_reg     <= IF_BUSY;
                        last_ls_reg   <= 1'b0;
                        cnt_reg       <= '0;
                        addr_sel_reg  <= 1'b0;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= 1'b0;
                        mem_addr_reg  <= addr_mux;
                        mem_wdata_reg <= 32'd0;
                        mem_be_reg    <= 4'hF;
                        if_gnt_reg    <= 1'b1;
                    end
                end
                default: begin
                    if (done || expire) begin
                        state_reg   <= IDLE;
                        mem_req_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a scoreboard queue holds the expected completion/timeout
// pulses, and a negedge monitor pops and compares them as the arbiter produces them.
module tb_mem_port_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [35:0] sb[$];

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {if_rvalid, if_err, ls_rvalid, ls_err, rdata}
    function automatic logic [35:0] resp(input logic ifv, input logic ife, input logic lsv,
                                         input logic lse, input logic [31:0] d);
        return {ifv, ife, lsv, lse, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cycle();
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        logic [35:0] obs;
        obs = {bus.if_rvalid, bus.if_err, bus.ls_rvalid, bus.ls_err, bus.rdata};
        check("gnt_exclusive", {63'd0, bus.if_gnt & bus.ls_gnt}, 64'd0);
        if (obs[35:32] != 4'd0) begin
            if (sb.size() == 0) check("unexpected_pulse", {28'd0, obs}, 64'd0);
            else check("sb_resp", {28'd0, obs}, {28'd0, sb.pop_front()});
        end else begin
            check("rdata_quiet", {32'd0, bus.rdata}, 64'd0);
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = 0; bus.ls_req = 0; bus.ls_we = 0;
        bus.ls_addr = 0; bus.ls_wdata = 0; bus.ls_be = 0;
        bus.mem_ready = 0; bus.mem_rdata = 0;
        do_cycle(); do_cycle();
        check("reset_outputs", {bus.mem_req, bus.if_gnt, bus.ls_gnt, bus.addr_sel, bus.mem_we,
                                bus.mem_be, bus.mem_addr, bus.mem_wdata}, 64'd0);
        rst = 1'b0;
        do_cycle();

        // 1. single fetch, ready two cycles after grant
        bus.if_req = 1; bus.if_addr = 32'h100;
        do_cycle();
        check("t1_if_gnt", {62'd0, bus.if_gnt, bus.ls_gnt}, 64'b10);
        check("t1_addr", {bus.mem_req, bus.addr_sel, bus.mem_we, bus.mem_be, bus.mem_addr},
              {25'd0, 1'b1, 1'b0, 1'b0, 4'hF, 32'h100});
        bus.if_req = 0;
        do_cycle();
        check("t1_gnt_pulse", {63'd0, bus.if_gnt}, 64'd0);
        do_cycle();
        bus.mem_rdata = 32'h00500093; bus.mem_ready = 1;
        sb.push_back(resp(1, 0, 0, 0, 32'h00500093));
        #1;
        check("t1_rvalid", {31'd0, bus.if_rvalid, bus.rdata}, {31'd0, 1'b1, 32'h00500093});
        do_cycle();
        bus.mem_ready = 0;
        check("t1_req_drop", {63'd0, bus.mem_req}, 64'd0);

        // 2. conflict: LS first (load), IF next
        bus.if_req = 1; bus.if_addr = 32'h104;
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h3000; bus.ls_be = 4'hF;
        do_cycle();
        check("t2_ls_first", {61'd0, bus.ls_gnt, bus.if_gnt, bus.addr_sel}, 64'b101);
        check("t2_ls_addr", {32'd0, bus.mem_addr}, 64'h3000);
        bus.ls_req = 0;
        do_cycle();
        bus.mem_rdata = 32'h11111111; bus.mem_ready = 1;
        sb.push_back(resp(0, 0, 1, 0, 32'h11111111));
        do_cycle();
        bus.mem_ready = 0;
        check("t2_idle_gap", {62'd0, bus.mem_req, bus.if_gnt}, 64'd0);
        do_cycle();
        check("t2_if_second", {61'd0, bus.if_gnt, bus.ls_gnt, bus.addr_sel}, 64'b100);
        check("t2_if_addr", {32'd0, bus.mem_addr}, 64'h104);

        // 6. requests during IF_BUSY are ignored; hold both for the next conflict
        bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 32'h2004;
        bus.ls_wdata = 32'hDEADBEEF; bus.ls_be = 4'b0011; bus.if_addr = 32'h108;
        do_cycle();
        check("t6_no_gnt_busy", {62'd0, bus.if_gnt, bus.ls_gnt}, 64'd0);
        do_cycle();
        check("t6_no_gnt_busy2", {61'd0, bus.if_gnt, bus.ls_gnt, bus.mem_req}, 64'b001);
        bus.mem_rdata = 32'h22222222; bus.mem_ready = 1;
        sb.push_back(resp(1, 0, 0, 0, 32'h22222222));
        do_cycle();
        bus.mem_ready = 0;
        do_cycle();

        // 3. store wins the repeated conflict; fields held until mem_ready
        check("t3_ls_third", {61'd0, bus.ls_gnt, bus.if_gnt, bus.addr_sel}, 64'b101);
        bus.ls_req = 0; bus.ls_we = 0; bus.ls_wdata = 0; bus.ls_be = 0; bus.ls_addr = 0;
        for (int i = 0; i < 3; i++) begin
            check("t3_store_held", {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata},
                  {1'b1, 4'b0011, 32'h2004, 32'hDEADBEEF});
            do_cycle();
        end
        bus.mem_rdata = 32'hCAFEF00D; bus.mem_ready = 1;
        sb.push_back(resp(0, 0, 1, 0, 32'd0));
        #1;
        check("t3_store_done", {31'd0, bus.ls_rvalid, bus.rdata}, {31'd0, 1'b1, 32'd0});
        do_cycle();
        bus.mem_ready = 0;
        do_cycle();
        check("t3_if_after", {62'd0, bus.if_gnt, bus.mem_be == 4'hF}, 64'b11);
        bus.if_req = 0;
        do_cycle();
        bus.mem_rdata = 32'h33333333; bus.mem_ready = 1;
        sb.push_back(resp(1, 0, 0, 0, 32'h33333333));
        do_cycle();
        bus.mem_ready = 0;
        do_cycle();

        // 4. LS load timeout on the 16th BUSY cycle
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h4000; bus.ls_be = 4'hF;
        do_cycle();
        check("t4_gnt", {63'd0, bus.ls_gnt}, 64'd1);
        bus.ls_req = 0;
        for (int i = 2; i <= 15; i++) begin
            do_cycle();
            if (i == 15) check("t4_no_err_early", {62'd0, bus.ls_err, bus.mem_req}, 64'b01);
        end
        do_cycle();
        sb.push_back(resp(0, 0, 0, 1, 32'd0));
        check("t4_err", {62'd0, bus.ls_err, bus.ls_rvalid}, 64'b10);
        do_cycle();
        check("t4_req_low", {62'd0, bus.mem_req, bus.ls_err}, 64'd0);

        // mem_ready on the expiry cycle wins over the timeout
        bus.if_req = 1; bus.if_addr = 32'h180;
        do_cycle();
        bus.if_req = 0;
        for (int i = 2; i <= 15; i++) do_cycle();
        do_cycle();
        bus.mem_rdata = 32'h44444444; bus.mem_ready = 1;
        sb.push_back(resp(1, 0, 0, 0, 32'h44444444));
        #1;
        check("t4_ready_wins", {62'd0, bus.if_rvalid, bus.if_err}, 64'b10);
        do_cycle();
        bus.mem_ready = 0;

        // 5. reset in the middle of IF_BUSY
        bus.if_req = 1; bus.if_addr = 32'h200;
        do_cycle();
        bus.if_req = 0;
        do_cycle();
        rst = 1'b1; bus.mem_ready = 1; bus.mem_rdata = 32'h55555555;
        #1;
        check("t5_async_drop", {bus.mem_req, bus.if_rvalid, bus.addr_sel, bus.mem_be,
                                bus.mem_addr}, 64'd0);
        do_cycle();
        bus.mem_ready = 0;
        rst = 1'b0;
        bus.if_req = 1; bus.ls_req = 1; bus.ls_addr = 32'h5000; bus.ls_we = 0;
        do_cycle();
        check("t5_ls_after_rst", {62'd0, bus.ls_gnt, bus.if_gnt}, 64'b10);
        bus.ls_req = 0; bus.if_req = 0;
        do_cycle();
        bus.mem_rdata = 32'h66666666; bus.mem_ready = 1;
        sb.push_back(resp(0, 0, 1, 0, 32'h66666666));
        do_cycle();

        // 6. mem_ready while IDLE produces nothing
        do_cycle();
        do_cycle();
        check("t6_idle_ready", {60'd0, bus.mem_req, bus.if_rvalid, bus.ls_rvalid, bus.if_err},
              64'd0);
        bus.mem_ready = 0;
        do_cycle();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
